// File: rtl/osc_capture_ctrl.sv
// Oscilloscope acquisition controller: streams ADC samples into a circular
// sample buffer with pre-trigger depth and level/slope trigger detection.
module osc_capture_ctrl #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 32768,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              force_trig,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] pretrig_q;
    logic              slope_q;
    logic [CNT_W-1:0]  pre_cnt_q;
    logic [CNT_W-1:0]  post_cnt_q;
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;

    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] mem_writedata_q;
    logic              busy_q;
    logic              done_q;
    logic              triggered_q;
    logic [ADDR_W-1:0] trig_addr_q;
    logic [ADDR_W-1:0] start_addr_q;

    logic              capturing_c;
    logic              accept_c;
    logic              rise_c;
    logic              fall_c;
    logic              trig_c;
    logic [CNT_W-1:0]  pre_cnt_d;
    logic [CNT_W-1:0]  post_cnt_d;
    logic [CNT_W-1:0]  post_len_c;

    // A sample is taken only in a busy state, and never on an arm/abort edge.
    assign capturing_c = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign accept_c    = sample_valid && capturing_c && !arm && !abort;

    assign rise_c = prev_valid_q && (prev_q < trig_level) && (sample_data >= trig_level);
    assign fall_c = prev_valid_q && (prev_q > trig_level) && (sample_data <= trig_level);
    assign trig_c = accept_c && (state_q == S_ARMED) &&
                    (force_trig || (slope_q ? fall_c : rise_c));

    // The trigger sample is post sample 1; the record closes after DEPTH - pretrig of them.
    assign pre_cnt_d  = pre_cnt_q + CNT_W'(1);
    assign post_cnt_d = (state_q == S_ARMED) ? CNT_W'(1) : (post_cnt_q + CNT_W'(1));
    assign post_len_c = CNT_W'(DEPTH) - CNT_W'(pretrig_q);

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = (pretrig == '0) ? S_ARMED : S_PRE;
        end else if (abort) begin
            state_d = S_IDLE;
        end else if (accept_c) begin
            case (state_q)
                S_PRE:   if (pre_cnt_d == CNT_W'(pretrig_q)) state_d = S_ARMED;
                S_ARMED: if (trig_c) state_d = (post_cnt_d == post_len_c) ? S_DONE : S_POST;
                S_POST:  if (post_cnt_d == post_len_c) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wptr_q          <= '0;
            pretrig_q       <= '0;
            slope_q         <= 1'b0;
            pre_cnt_q       <= '0;
            post_cnt_q      <= '0;
            prev_q          <= '0;
            prev_valid_q    <= 1'b0;
            mem_address_q   <= '0;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            triggered_q     <= 1'b0;
            trig_addr_q     <= '0;
            start_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
            mem_write_q <= accept_c;

            if (accept_c) begin
                mem_address_q   <= wptr_q;
                mem_writedata_q <= sample_data;
                wptr_q          <= wptr_q + ADDR_W'(1);
                prev_q          <= sample_data;
                prev_valid_q    <= 1'b1;
            end

            if (arm) begin
                pretrig_q    <= pretrig;
                slope_q      <= trig_slope;
                pre_cnt_q    <= '0;
                post_cnt_q   <= '0;
                prev_valid_q <= 1'b0;
                done_q       <= 1'b0;
                triggered_q  <= 1'b0;
            end else if (accept_c) begin
                if (state_q == S_PRE) begin
                    pre_cnt_q <= pre_cnt_d;
                end
                if (trig_c) begin
                    trig_addr_q  <= wptr_q;
                    start_addr_q <= wptr_q - pretrig_q;
                    triggered_q  <= 1'b1;
                end
                if (trig_c || (state_q == S_POST)) begin
                    post_cnt_q <= post_cnt_d;
                end
                if (state_d == S_DONE) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign triggered      = triggered_q;
    assign trig_addr      = trig_addr_q;
    assign start_addr     = start_addr_q;

endmodule
